// File: rtl/sram_responder.sv
// Single-port word SRAM slave with fixed access latency and range checking.
// One outstanding request; valid/ready handshakes on both request and response.
module sram_responder #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
    localparam logic [3:0]  LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic [3:0]      cnt_dec;

    logic            wen_q;
    logic            inr_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wmask_q;

    logic            req_ready_q;
    logic            rsp_valid_q;
    logic            rsp_err_q;
    logic [31:0]     rsp_rdata_q;

    logic [31:0]     mem [DEPTH];

    logic [31:0]     off;
    logic            in_inr;
    logic [AW-1:0]   in_idx;
    logic            accept;
    logic            commit;

    logic            op_wen;
    logic            op_inr;
    logic [AW-1:0]   op_idx;
    logic [31:0]     op_wdata;
    logic [3:0]      op_wmask;

    logic [31:0]     rsp_rdata_d;
    logic            rsp_err_d;

    // Unsigned offset: addresses below BASE wrap high and fail the span test.
    assign off     = req_addr - BASE;
    assign in_inr  = {1'b0, off} < SPAN;
    assign in_idx  = off[AW+1:2];

    assign accept  = (state_q == IDLE) && req_valid;
    assign cnt_dec = cnt_q - 4'd1;

    // Edge on which the access takes effect (entry into RESP).
    assign commit  = !rst &&
                     (((state_q == WAIT) && (cnt_dec == 4'd0)) ||
                      (accept && (LATENCY == 1)));

    // With a single-cycle latency the access uses the live request.
    always_comb begin
        op_wen   = wen_q;
        op_inr   = inr_q;
        op_idx   = idx_q;
        op_wdata = wdata_q;
        op_wmask = wmask_q;
        if (state_q == IDLE) begin
            op_wen   = req_wen;
            op_inr   = in_inr;
            op_idx   = in_idx;
            op_wdata = req_wdata;
            op_wmask = req_wmask;
        end
    end

    always_comb begin
        rsp_rdata_d = '0;
        rsp_err_d   = !op_inr;
        if (op_inr && !op_wen) begin
            rsp_rdata_d = mem[op_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (commit && op_wen && op_inr) begin
            for (int b = 0; b < 4; b++) begin
                if (op_wmask[b]) begin
                    mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wen_q       <= 1'b0;
            inr_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wen_q       <= req_wen;
                        inr_q       <= in_inr;
                        idx_q       <= in_idx;
                        wdata_q     <= req_wdata;
                        wmask_q     <= req_wmask;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q     <= RESP;
                            cnt_q       <= '0;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rsp_rdata_d;
                            rsp_err_q   <= rsp_err_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= LOAD;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_dec;
                    if (cnt_dec == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= rsp_err_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench: LATENCY=2 instance for directed scenarios,
// LATENCY=1 instance for the back-to-back stream.
module tb_sram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        b_req_valid, b_req_ready, b_req_wen;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_wmask;
    logic        b_rsp_valid, b_rsp_ready;
    logic [31:0] b_rsp_rdata;
    logic        b_rsp_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [32:0] sb0[$];
    logic [32:0] sb1[$];
    logic [31:0] m0[int];
    logic [31:0] m1[int];

    sram_responder #(.BASE(32'h8000_0000), .DEPTH(1024), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    sram_responder #(.BASE(32'h8000_0000), .DEPTH(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    // Reference memory: returns {err, rdata} and applies in-range writes.
    function automatic logic [32:0] apply(input bit which, input logic wen,
                                          input logic [31:0] addr,
                                          input logic [31:0] wd,
                                          input logic [3:0] wm);
        logic [31:0] o;
        logic [31:0] w;
        int idx;
        o = addr - 32'h8000_0000;
        if (o >= 32'h0000_1000) return {1'b1, 32'h0};
        idx = int'(o >> 2);
        w = 32'h0;
        if (which && m1.exists(idx)) w = m1[idx];
        if (!which && m0.exists(idx)) w = m0[idx];
        if (!wen) return {1'b0, w};
        for (int b = 0; b < 4; b++) begin
            if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
        end
        if (which) m1[idx] = w;
        else m0[idx] = w;
        return {1'b0, 32'h0};
    endfunction

    // One transaction on the LATENCY=2 instance; entered and left at a negedge.
    task automatic xfer(input logic wen, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] wm,
                        input int hold,
                        output logic [31:0] rd, output logic er);
        int cyc;
        logic [32:0] exp;
        rd = '0;
        er = 1'b0;
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wd;
        req_wmask = wm;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout addr=%h", addr);
            req_valid = 1'b0;
            return;
        end
        sb0.push_back(apply(1'b0, wen, addr, wd, wm));
        @(negedge clk);
        req_valid = 1'b0;
        req_wen   = 1'b1;
        req_wdata = $urandom;
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (!rsp_valid || cyc != 2) begin
            miscompares++;
            $display("FAIL latency addr=%h got=%0d want=2", addr, cyc);
        end
        if (!rsp_valid) begin
            void'(sb0.pop_front());
            return;
        end
        exp = sb0[0];
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            vectors++;
            if (rsp_valid !== 1'b1 || {rsp_err, rsp_rdata} !== exp ||
                req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold h=%0d v=%b rd=%h err=%b rr=%b want rd=%h err=%b",
                         h, rsp_valid, rsp_rdata, rsp_err, req_ready,
                         exp[31:0], exp[32]);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        exp = sb0.pop_front();
        rd = rsp_rdata;
        er = rsp_err;
        vectors++;
        if ({er, rd} !== exp) begin
            miscompares++;
            $display("FAIL rsp addr=%h got rd=%h err=%b want rd=%h err=%b",
                     addr, rd, er, exp[31:0], exp[32]);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
            rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL release rr=%b v=%b rd=%h err=%b want 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
            rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_l2 rr=%b v=%b rd=%h err=%b want 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        vectors++;
        if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0 ||
            b_rsp_rdata !== 32'h0 || b_rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_l1 rr=%b v=%b rd=%h err=%b want 1 0 0 0",
                     b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic er;
        xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
        xfer(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er);
        vectors++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_read got=%h/%b want=deadbeef/0", rd, er);
        end
    endtask

    task automatic test_mask();
        logic [31:0] rd;
        logic er;
        xfer(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 0, rd, er);
        xfer(1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0100, 0, rd, er);
        xfer(1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er);
        vectors++;
        if (rd !== 32'h11BB_3344) begin
            miscompares++;
            $display("FAIL mask_read got=%h want=11bb3344", rd);
        end
        xfer(1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
        xfer(1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er);
        vectors++;
        if (rd !== 32'h11BB_3344) begin
            miscompares++;
            $display("FAIL zero_mask got=%h want=11bb3344", rd);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd;
        logic er;
        xfer(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, rd, er);
        vectors++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL below_base got=%h/%b want=0/1", rd, er);
        end
        xfer(1'b0, 32'h8000_1000, 32'h0, 4'h0, 0, rd, er);
        vectors++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL past_end got=%h/%b want=0/1", rd, er);
        end
        xfer(1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 0, rd, er);
        vectors++;
        if (er !== 1'b0) begin
            miscompares++;
            $display("FAIL last_word err=%b want=0", er);
        end
        xfer(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, rd, er);
        xfer(1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
        vectors++;
        if (er !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_write err=%b want=1", er);
        end
        xfer(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, rd, er);
        vectors++;
        if (rd !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL word0_kept got=%h want=cafef00d", rd);
        end
    endtask

    task automatic test_stall();
        logic [31:0] rd;
        logic er;
        xfer(1'b1, 32'h8000_0030, 32'h5A5A_1234, 4'hF, 5, rd, er);
        xfer(1'b0, 32'h8000_0030, 32'h0, 4'h0, 5, rd, er);
        vectors++;
        if (rd !== 32'h5A5A_1234) begin
            miscompares++;
            $display("FAIL stall_read got=%h want=5a5a1234", rd);
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd;
        logic er;
        xfer(1'b1, 32'h8000_0004, 32'h0, 4'hF, 0, rd, er);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h8000_0004;
        req_wdata = 32'h1234_5678;
        req_wmask = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
            rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset rr=%b v=%b rd=%h err=%b want 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(1'b0, 32'h8000_0004, 32'h0, 4'h0, 0, rd, er);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL dropped_write got=%h want=0", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [8];
        logic [31:0] datas [8];
        logic        wens  [8];
        logic [32:0] exp;
        int n;
        int cyc;
        int last;
        addrs = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_0000,
                  32'h8000_0004, 32'h8000_0008, 32'h8000_2000, 32'h8000_0004};
        datas = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0,
                  32'h0, 32'h0, 32'h0, 32'h0};
        wens  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        b_rsp_ready = 1'b1;
        n = 0;
        cyc = 0;
        last = -1;
        while ((n < 8 || sb1.size() != 0) && cyc < 100) begin
            cyc++;
            if (b_rsp_valid) begin
                vectors++;
                if (sb1.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_extra rd=%h", b_rsp_rdata);
                end else begin
                    exp = sb1.pop_front();
                    if ({b_rsp_err, b_rsp_rdata} !== exp) begin
                        miscompares++;
                        $display("FAIL b2b_rsp got=%h/%b want=%h/%b",
                                 b_rsp_rdata, b_rsp_err, exp[31:0], exp[32]);
                    end
                end
            end
            if (b_req_ready && n < 8) begin
                b_req_valid = 1'b1;
                b_req_wen   = wens[n];
                b_req_addr  = addrs[n];
                b_req_wdata = datas[n];
                b_req_wmask = 4'hF;
                sb1.push_back(apply(1'b1, wens[n], addrs[n], datas[n], 4'hF));
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last != 2) begin
                        miscompares++;
                        $display("FAIL b2b_rate gap=%0d want=2", cyc - last);
                    end
                end
                last = cyc;
                n++;
            end else if (b_req_ready) begin
                b_req_valid = 1'b0;
            end else begin
                // Garbage write while busy must be ignored.
                b_req_valid = 1'b1;
                b_req_wen   = 1'b1;
                b_req_addr  = 32'h8000_0004;
                b_req_wdata = $urandom;
                b_req_wmask = 4'hF;
            end
            @(negedge clk);
        end
        b_req_valid = 1'b0;
        vectors++;
        if (n != 8 || sb1.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_timeout sent=%0d pending=%0d", n, sb1.size());
        end
    endtask

    initial begin
        req_valid   = 1'b0;
        req_wen     = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wmask   = '0;
        rsp_ready   = 1'b0;
        b_req_valid = 1'b0;
        b_req_wen   = 1'b0;
        b_req_addr  = '0;
        b_req_wdata = '0;
        b_req_wmask = '0;
        b_rsp_ready = 1'b1;
        test_reset();
        test_basic();
        test_mask();
        test_range();
        test_stall();
        test_reset_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
